// File: rtl/e1_tx_bd_mgr.sv
// E1 TX buffer-descriptor manager and per-channel CSR block.
// Each channel has its own BD-in/BD-out FIFOs, underflow counter, repeat
// replay register and IRQ enables; the top decodes the bus and merges IRQs.

module e1_tx_bd_ch #(
  parameter int MFW   = 7,
  parameter int DEPTH = 4,
  parameter int UCW   = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           sel,
  input  logic [1:0]     reg_addr,
  input  logic           we,
  input  logic [15:0]    wdata,
  input  logic           clr,
  output logic [15:0]    rdata,
  output logic [MFW-1:0] bd_mf,
  output logic [1:0]     bd_crc_e,
  output logic           bd_valid,
  input  logic           bd_done,
  input  logic           bd_miss,
  input  logic [1:0]     crc_e_auto,
  output logic           ctrl_rst,
  output logic [1:0]     ctrl_mode,
  output logic           ctrl_time_src,
  output logic           ctrl_alarm,
  output logic           ctrl_loopback,
  output logic           irq_req
);
  localparam int AW   = $clog2(DEPTH);
  localparam int CNTW = AW + 1;
  localparam int EW   = MFW + 2;

  logic [6:0]     cfg;
  logic           en_done, en_und, und_flag, bti_ovr, bto_ovf, last_vld;
  logic [UCW-1:0] und_cnt;
  logic [MFW-1:0] last_mf;
  logic [1:0]     last_crc;

  logic [EW-1:0]  bti_mem [DEPTH];
  logic [AW-1:0]  bti_wp, bti_rp;
  logic [CNTW-1:0] bti_cnt;
  logic [MFW-1:0] bto_mem [DEPTH];
  logic [AW-1:0]  bto_wp, bto_rp;
  logic [CNTW-1:0] bto_cnt;

  logic wr_q, push_q, ovr_q, pop_q;
  logic [1:0]  reg_q;
  logic [15:0] wdata_q;

  logic bti_full, bti_empty, bto_full, bto_empty, bti_full_acc, bto_avail_acc;
  logic wr_csr, wr_r2, bti_push, bti_pop, bto_push, bto_pop, ovr_set, ovf_set;
  logic flush, rep, use_last, und_inc;
  logic [EW-1:0] head;
  logic unused_wdata;

  assign bti_full  = (bti_cnt == CNTW'(DEPTH));
  assign bti_empty = (bti_cnt == '0);
  assign bto_full  = (bto_cnt == CNTW'(DEPTH));
  assign bto_empty = (bto_cnt == '0);
  // A strobe still pending from the previous access counts toward the
  // access-cycle decision so back-to-back accesses cannot overfill/overpop.
  assign bti_full_acc  = bti_full | (push_q & (bti_cnt == CNTW'(DEPTH - 1)));
  assign bto_avail_acc = ~bto_empty & ~(pop_q & (bto_cnt == CNTW'(1)));

  assign wr_csr   = wr_q & ~clr & (reg_q == 2'd0);
  assign wr_r2    = wr_q & ~clr & (reg_q == 2'd2);
  assign bti_push = push_q & ~clr;
  assign ovr_set  = ovr_q & ~clr;
  assign bto_pop  = pop_q & ~clr;
  assign flush    = wr_csr & ~wdata_q[0];

  assign rep      = cfg[6];
  assign head     = bti_mem[bti_rp];
  assign use_last = rep & bti_empty;
  assign bti_pop  = bd_done & ~bti_empty;
  assign bto_push = bti_pop & ~bto_full;
  assign ovf_set  = bti_pop & bto_full;
  assign und_inc  = bd_miss | (bd_done & rep & bti_empty & last_vld);
  assign unused_wdata = ^{wdata_q[11:10], wdata_q[7]};

  assign bd_valid      = ~bti_empty | (rep & last_vld);
  assign bd_mf         = use_last ? last_mf : head[MFW-1:0];
  assign bd_crc_e      = (cfg[2:1] == 2'b11) ? crc_e_auto : (use_last ? last_crc : head[MFW +: 2]);
  assign ctrl_mode     = cfg[2:1];
  assign ctrl_time_src = cfg[3];
  assign ctrl_alarm    = cfg[4];
  assign ctrl_loopback = cfg[5];
  assign irq_req       = (en_done & ~bto_empty) | (en_und & und_flag);

  // Register bus accesses into next-cycle strobes; FIFO checks use access-cycle state.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= 1'b0; push_q <= 1'b0; ovr_q <= 1'b0; pop_q <= 1'b0;
      reg_q <= '0; wdata_q <= '0;
    end else begin
      wr_q    <= sel & we;
      reg_q   <= reg_addr;
      wdata_q <= wdata;
      push_q  <= sel & we & (reg_addr == 2'd1) & ~bti_full_acc;
      ovr_q   <= sel & we & (reg_addr == 2'd1) & bti_full_acc;
      pop_q   <= sel & ~we & (reg_addr == 2'd1) & bto_avail_acc;
    end
  end

  // FIFO storage (data only, no reset needed).
  always_ff @(posedge clk) begin
    if (bti_push) bti_mem[bti_wp] <= {wdata_q[14:13], wdata_q[MFW-1:0]};
    if (bto_push) bto_mem[bto_wp] <= head[MFW-1:0];
  end

  // FIFO pointers and counts; a disabling CSR write flushes both.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      bti_wp <= '0; bti_rp <= '0; bti_cnt <= '0;
      bto_wp <= '0; bto_rp <= '0; bto_cnt <= '0;
    end else begin
      if (bti_push) bti_wp <= bti_wp + AW'(1);
      if (bti_pop)  bti_rp <= bti_rp + AW'(1);
      bti_cnt <= bti_cnt + CNTW'(bti_push) - CNTW'(bti_pop);
      if (bto_push) bto_wp <= bto_wp + AW'(1);
      if (bto_pop)  bto_rp <= bto_rp + AW'(1);
      bto_cnt <= bto_cnt + CNTW'(bto_push) - CNTW'(bto_pop);
    end
  end

  // Last-consumed BD, replayed when the BD-in FIFO runs dry in repeat mode.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_vld <= 1'b0; last_mf <= '0; last_crc <= '0;
    end else if (flush) begin
      last_vld <= 1'b0;
    end else if (bti_pop) begin
      last_vld <= 1'b1;
      last_mf  <= head[MFW-1:0];
      last_crc <= head[MFW +: 2];
    end
  end

  // Config, IRQ enables, sticky flags (set beats clear), underflow counter (clear beats inc).
  always_ff @(posedge clk) begin
    if (rst) begin
      cfg <= '0; en_done <= 1'b1; en_und <= 1'b1;
      und_flag <= 1'b0; bti_ovr <= 1'b0; bto_ovf <= 1'b0;
      und_cnt <= '0; ctrl_rst <= 1'b1;
    end else begin
      if (wr_csr) cfg <= wdata_q[6:0];
      if (wr_r2) begin
        en_done <= wdata_q[9];
        en_und  <= wdata_q[8];
      end
      und_flag <= und_inc | (und_flag & ~(wr_csr & wdata_q[12]));
      bti_ovr  <= ovr_set | (bti_ovr & ~(wr_csr & wdata_q[13]));
      bto_ovf  <= ovf_set | (bto_ovf & ~(wr_csr & wdata_q[14]));
      if (wr_r2 && wdata_q[15])           und_cnt <= '0;
      else if (und_inc && und_cnt != '1)  und_cnt <= und_cnt + UCW'(1);
      ctrl_rst <= ~cfg[0];
    end
  end

  // Combinational register readback.
  always_comb begin
    rdata = '0;
    case (reg_addr)
      2'd0: rdata = {1'b0, bto_ovf, bti_ovr, und_flag, bto_full, bto_empty,
                     bti_full, bti_empty, 1'b0, cfg};
      2'd1: begin
        rdata[15] = ~bto_empty;
        if (!bto_empty) rdata[MFW-1:0] = bto_mem[bto_rp];
      end
      2'd2: begin
        rdata[9:8]     = {en_done, en_und};
        rdata[UCW-1:0] = und_cnt;
      end
      default: rdata = '0;
    endcase
  end
endmodule

module e1_tx_bd_mgr #(
  parameter int NCH   = 1,
  parameter int MFW   = 7,
  parameter int DEPTH = 4,
  parameter int UCW   = 8,
  localparam int CW   = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               bus_addr_sel,
  input  logic [CW+1:0]      bus_addr,
  input  logic [15:0]        bus_wdata,
  output logic [15:0]        bus_rdata,
  input  logic               bus_clr,
  input  logic               bus_we,
  output logic [NCH*MFW-1:0] bd_mf,
  output logic [NCH*2-1:0]   bd_crc_e,
  output logic [NCH-1:0]     bd_valid,
  input  logic [NCH-1:0]     bd_done,
  input  logic [NCH-1:0]     bd_miss,
  input  logic [NCH*2-1:0]   crc_e_auto,
  output logic [NCH-1:0]     crc_e_ack,
  output logic [NCH-1:0]     ctrl_rst,
  output logic [NCH*2-1:0]   ctrl_mode,
  output logic [NCH-1:0]     ctrl_time_src,
  output logic [NCH-1:0]     ctrl_alarm,
  output logic [NCH-1:0]     ctrl_loopback,
  output logic               irq
);
  logic [NCH-1:0]       ch_sel, irq_req;
  logic [NCH-1:0][15:0] ch_rd;

  assign crc_e_ack = bd_done;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    assign ch_sel[i] = bus_addr_sel & (bus_addr[CW+1:2] == CW'(i));
    e1_tx_bd_ch #(.MFW(MFW), .DEPTH(DEPTH), .UCW(UCW)) u_ch (
      .clk(clk), .rst(rst), .sel(ch_sel[i]), .reg_addr(bus_addr[1:0]),
      .we(bus_we), .wdata(bus_wdata), .clr(bus_clr), .rdata(ch_rd[i]),
      .bd_mf(bd_mf[i*MFW +: MFW]), .bd_crc_e(bd_crc_e[i*2 +: 2]),
      .bd_valid(bd_valid[i]), .bd_done(bd_done[i]), .bd_miss(bd_miss[i]),
      .crc_e_auto(crc_e_auto[i*2 +: 2]), .ctrl_rst(ctrl_rst[i]),
      .ctrl_mode(ctrl_mode[i*2 +: 2]), .ctrl_time_src(ctrl_time_src[i]),
      .ctrl_alarm(ctrl_alarm[i]), .ctrl_loopback(ctrl_loopback[i]),
      .irq_req(irq_req[i])
    );
  end

  // Read mux: only the selected, existing channel drives the bus.
  always_comb begin
    bus_rdata = '0;
    for (int i = 0; i < NCH; i++)
      if (ch_sel[i]) bus_rdata = bus_rdata | ch_rd[i];
  end

  // Registered interrupt, one cycle behind the per-channel sources.
  always_ff @(posedge clk) begin
    if (rst) irq <= 1'b0;
    else     irq <= |irq_req;
  end
endmodule

// File: tb/tb_e1_tx_bd_mgr.sv
// Directed bench for e1_tx_bd_mgr with two channels, DEPTH 4, UCW 8.
module tb_e1_tx_bd_mgr;
  localparam int NCH = 2, MFW = 7, DEPTH = 4, UCW = 8, CW = 1;

  logic               clk = 1'b0;
  logic               rst, bus_addr_sel, bus_clr, bus_we;
  logic [CW+1:0]      bus_addr;
  logic [15:0]        bus_wdata, bus_rdata;
  logic [NCH*MFW-1:0] bd_mf;
  logic [NCH*2-1:0]   bd_crc_e, crc_e_auto, ctrl_mode;
  logic [NCH-1:0]     bd_valid, bd_done, bd_miss, crc_e_ack, ctrl_rst;
  logic [NCH-1:0]     ctrl_time_src, ctrl_alarm, ctrl_loopback;
  logic               irq;

  int errors = 0, checks = 0;

  e1_tx_bd_mgr #(.NCH(NCH), .MFW(MFW), .DEPTH(DEPTH), .UCW(UCW)) dut (
    .clk(clk), .rst(rst), .bus_addr_sel(bus_addr_sel), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_clr(bus_clr), .bus_we(bus_we),
    .bd_mf(bd_mf), .bd_crc_e(bd_crc_e), .bd_valid(bd_valid), .bd_done(bd_done),
    .bd_miss(bd_miss), .crc_e_auto(crc_e_auto), .crc_e_ack(crc_e_ack),
    .ctrl_rst(ctrl_rst), .ctrl_mode(ctrl_mode), .ctrl_time_src(ctrl_time_src),
    .ctrl_alarm(ctrl_alarm), .ctrl_loopback(ctrl_loopback), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic bwr(input int ch, input int r, input logic [15:0] d, input bit clr_stb = 1'b0);
    bus_addr_sel = 1'b1; bus_we = 1'b1; bus_addr = 3'(ch * 4 + r); bus_wdata = d;
    tick();
    bus_addr_sel = 1'b0; bus_we = 1'b0; bus_clr = clr_stb;
    tick();
    bus_clr = 1'b0;
  endtask

  task automatic rdchk(input string tag, input int ch, input int r, input logic [15:0] exp);
    logic [15:0] d;
    bus_addr_sel = 1'b1; bus_we = 1'b0; bus_addr = 3'(ch * 4 + r);
    #1 d = bus_rdata;
    chk(tag, d, exp);
    tick();
    bus_addr_sel = 1'b0;
    tick();
  endtask

  task automatic done0();
    bd_done[0] = 1'b1;
    tick();
    bd_done[0] = 1'b0;
  endtask

  initial begin
    rst = 1'b1; bus_addr_sel = 1'b0; bus_clr = 1'b0; bus_we = 1'b0;
    bus_addr = '0; bus_wdata = '0; bd_done = '0; bd_miss = '0; crc_e_auto = '0;
    repeat (3) tick();
    chk("rst_ctrl_rst", 16'(ctrl_rst), 16'h0003);
    rst = 1'b0;
    tick();
    chk("rst_irq", 16'(irq), 16'h0000);
    chk("rst_bd_valid", 16'(bd_valid), 16'h0000);
    rdchk("rst_csr0", 0, 0, 16'h0500);
    rdchk("rst_reg2", 0, 2, 16'h0300);
    rdchk("rst_reg3", 0, 3, 16'h0000);

    // 1: enable ch0, mode 01; ctrl_rst falls two edges after the access
    bwr(0, 0, 16'h0003);
    chk("t1_ctrl_rst_hold", 16'(ctrl_rst), 16'h0003);
    tick();
    chk("t1_ctrl_rst_fall", 16'(ctrl_rst), 16'h0002);
    chk("t1_mode", 16'(ctrl_mode), 16'h0001);
    rdchk("t1_csr", 0, 0, 16'h0503);
    bus_addr = 3'd1;
    #1 chk("t1_unsel_rdata", bus_rdata, 16'h0000);

    // 2: overfill bti, consume four BDs, drain bto
    for (int m = 1; m <= 5; m++) bwr(0, 1, 16'(m));
    chk("t2_valid", 16'(bd_valid), 16'h0001);
    chk("t2_mf", 16'(bd_mf[6:0]), 16'h0001);
    rdchk("t2_csr_full_ovr", 0, 0, 16'h2603);
    chk("t2_irq_pre", 16'(irq), 16'h0000);
    done0();
    chk("t2_irq_lat0", 16'(irq), 16'h0000);
    chk("t2_mf_next", 16'(bd_mf[6:0]), 16'h0002);
    tick();
    chk("t2_irq_lat1", 16'(irq), 16'h0001);
    for (int k = 0; k < 3; k++) done0();
    chk("t2_valid_empty", 16'(bd_valid), 16'h0000);
    rdchk("t2_csr_bto_full", 0, 0, 16'h2903);
    for (int k = 1; k <= 4; k++) rdchk("t2_bd_read", 0, 1, 16'h8000 | 16'(k));
    rdchk("t2_bd_read_empty", 0, 1, 16'h0000);
    bwr(0, 0, 16'h2003);
    rdchk("t2_csr_ovr_clr", 0, 0, 16'h0503);

    // 3: mode 3 takes E bits from crc_e_auto; ack mirrors done
    bwr(0, 0, 16'h0007);
    crc_e_auto = 4'b0010;
    bwr(0, 1, 16'h2005);
    chk("t3_crc_auto", 16'(bd_crc_e[1:0]), 16'h0002);
    bwr(0, 0, 16'h0003);
    chk("t3_crc_bd", 16'(bd_crc_e[1:0]), 16'h0001);
    bd_done[0] = 1'b1;
    #1 chk("t3_ack_hi", 16'(crc_e_ack), 16'h0001);
    tick();
    bd_done[0] = 1'b0;
    #1 chk("t3_ack_lo", 16'(crc_e_ack), 16'h0000);
    rdchk("t3_bto", 0, 1, 16'h8005);

    // 4: repeat mode replays mf 9 and counts underflows
    bwr(0, 0, 16'h0043);
    bwr(0, 1, 16'h0009);
    for (int k = 0; k < 4; k++) done0();
    chk("t4_valid", 16'(bd_valid), 16'h0001);
    chk("t4_mf", 16'(bd_mf[6:0]), 16'h0009);
    rdchk("t4_count", 0, 2, 16'h0303);
    rdchk("t4_csr_und", 0, 0, 16'h1143);
    chk("t4_irq", 16'(irq), 16'h0001);
    rdchk("t4_bto_one", 0, 1, 16'h8009);
    rdchk("t4_bto_empty", 0, 1, 16'h0000);

    // 5: saturation, clear-beats-increment, set-beats-clear
    bwr(0, 2, 16'h8300);
    bwr(0, 0, 16'h1043);
    bd_miss[0] = 1'b1;
    repeat (300) tick();
    bd_miss[0] = 1'b0;
    rdchk("t5_sat", 0, 2, 16'h03FF);
    bd_miss[0] = 1'b1;
    bwr(0, 2, 16'h8300);
    bd_miss[0] = 1'b0;
    rdchk("t5_clr_wins", 0, 2, 16'h0300);
    bd_miss[0] = 1'b1;
    bwr(0, 0, 16'h1043);
    bd_miss[0] = 1'b0;
    rdchk("t5_set_wins", 0, 0, 16'h1543);
    bwr(0, 0, 16'h1043);
    rdchk("t5_flag_clr", 0, 0, 16'h0543);

    // bus_clr in the strobe cycle suppresses the BD push
    bwr(0, 1, 16'h0011, 1'b1);
    rdchk("clr_no_push", 0, 0, 16'h0543);
    chk("clr_mf_replay", 16'(bd_mf[6:0]), 16'h0009);

    // 6: channel 1 fill then disable flushes; channel 0 untouched
    bwr(1, 0, 16'h0001);
    bwr(1, 1, 16'h0003);
    bwr(1, 1, 16'h0004);
    chk("t6_valid1", 16'(bd_valid), 16'h0003);
    chk("t6_mf1", 16'(bd_mf[13:7]), 16'h0003);
    rdchk("t6_csr1", 1, 0, 16'h0401);
    bwr(1, 0, 16'h0000);
    chk("t6_valid_flush", 16'(bd_valid), 16'h0001);
    rdchk("t6_csr1_flush", 1, 0, 16'h0500);
    chk("t6_ctrl_rst", 16'(ctrl_rst), 16'h0002);
    rdchk("t6_csr0_kept", 0, 0, 16'h0543);
    chk("t6_mf0_kept", 16'(bd_mf[6:0]), 16'h0009);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/e1_tx_bd_mgr.md
Name: e1_tx_bd_mgr

Overview:
Multi-channel, parametrised TX buffer-descriptor (BD) manager and CSR block for the E1 wishbone core. It serves NCH E1 TX cores. For each channel it provides:
- a control register;
- BD-in and BD-out FIFOs of configurable depth;
- a saturating underflow counter;
- per-source IRQ enables;
- a repeat mode that replays the last multiframe instead of missing.

It sits between the wishbone bus decoder and the e1_tx core instances and drives their bd_* and ctrl_* inputs.

Parameters:
NCH, 1, number of E1 TX channels (1..8).
MFW, 7, multiframe index width (≤13).
DEPTH, 4, entries per BD FIFO (power of 2, ≥2).
UCW, 8, underflow counter width (≤8).
CW (localparam), max(1, clog2(NCH)), channel select width.

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
bus_addr_sel  in  1  block selected
bus_addr  in  CW+2  {channel, reg[1:0]}
bus_wdata  in  16  write data
bus_rdata  out  16  read data; 0 when not selected
bus_clr  in  1  bus cycle end; suppresses strobes
bus_we  in  1  write access
bd_mf  out  NCH*MFW  per-channel BD multiframe index
bd_crc_e  out  NCH*2  per-channel E bits
bd_valid  out  NCH  BD available
bd_done  in  NCH  core consumed BD (1-cycle pulse)
bd_miss  in  NCH  core found no BD (1-cycle pulse)
crc_e_auto  in  NCH*2  auto E bits from RX
crc_e_ack  out  NCH  = bd_done
ctrl_rst  out  NCH  per-core reset
ctrl_mode  out  NCH*2  framing mode
ctrl_time_src  out  NCH  timing source
ctrl_alarm  out  NCH  alarm bit
ctrl_loopback  out  NCH  loopback
irq  out  1  registered interrupt

Behaviour:

Register map (per channel):
- reg0 CSR. Write:
  - [0] enable, [2:1] mode, [3] time_src, [4] alarm, [5] loopback, [6] repeat
  - [12] write-1 clears underflow flag; [13] clears BD-in overrun flag; [14] clears BD-out overflow flag.
- reg0 read: [14] bto_ovf, [13] bti_ovr, [12] und_flag, [11] bto_full, [10] bto_empty, [9] bti_full, [8] bti_empty, [6:0] config.
- reg1 BD write: [14:13] crc_e, [MFW-1:0] mf.
- reg1 BD read: [15] ~bto_empty, [MFW-1:0] mf, other bits 0.
- reg2 write: [9] irq_en_done, [8] irq_en_und, [15] write-1 clears counter.
- reg2 read: [9:8] enables, [UCW-1:0] underflow count.
- reg3: reads 0, writes ignored.

Bus timing and strobes:
- bus_rdata is combinational from current state.
- Write/pop strobes are registered one cycle after the access, and are zero in any cycle where bus_clr is high.
- BD write when bti full (sampled in the access cycle): dropped, sets bti_ovr.
- BD read pops only if bto was non-empty in the access cycle.

FIFOs:
- Count 0..DEPTH; full at DEPTH.
- Push and pop in the same cycle on a non-empty, non-full FIFO keeps the count unchanged.

Core interface:
- bd_valid = ~bti_empty, or (repeat & last_vld).
- bd_mf / bd_crc_e come from the bti head, or from the last-consumed register when bti is empty in repeat mode.
- If mode == 3, crc_e comes from crc_e_auto.
- bd_done with bti non-empty:
  - pop bti;
  - latch mf/crc_e into the last register and set last_vld;
  - push mf into bto if not full, else set bto_ovf.
- bd_done while replaying: no pop, no bto push; increments the counter (saturating at 2^UCW−1) and sets und_flag.
- bd_miss: increments the counter and sets und_flag.
- Counter clear and increment in the same cycle: clear wins. Flag clear and set in the same cycle: set wins.

Enable and reset:
- A write with enable = 0 flushes both FIFOs of that channel and clears last_vld on the strobe cycle.
- ctrl_rst is registered as ~enable; it is 1 while rst is asserted.

IRQ:
- irq <= OR over channels of (en_done & ~bto_empty) | (en_und & und_flag).
- One cycle of latency.

Reset (rst):
- All config 0; flags and counters 0.
- FIFOs empty; last_vld 0.
- irq enables both 1.
- irq 0, ctrl_rst all 1, bd_valid 0.

Test Plan:
1. Reset, then write CSR ch0 = 0x0003 → ctrl_rst[0] falls 2 cycles later and ctrl_mode[1:0] = 01. Read CSR → 0x0503 (both FIFOs empty).
2. Write 5 BDs mf = 1..5 with DEPTH = 4 → bd_valid = 1, bd_mf = 1. CSR shows bti_full and bti_ovr, so reading CSR returns 0x2603 (bit 12 clear, bit 11 clear, bit 10 set, bit 9 set, bit 8 clear). Pulse bd_done ×4 → bto holds 1..4, irq = 1 one cycle after the first done. Four BD reads return 0x8001..0x8004, then 0x0000.
3. Channel 0, mode 3, with crc_e_auto = 2'b10 and a BD carrying crc_e = 01 → bd_crc_e = 10. crc_e_ack pulses exactly with bd_done.
4. Repeat = 1, one BD mf = 9, consumed, then 3 more bd_done pulses → bd_valid stays 1, bd_mf = 9, reg2 count = 3, und_flag = 1, bto holds a single entry (9).
5. Pulse bd_miss 300 times with UCW = 8 → count saturates at 255. Writing reg2 bit 15 in the same cycle as a miss → count 0.
6. NCH = 2: fill channel 1 bti with 2 BDs, then write CSR ch1 enable = 0 → bti_empty[1] = 1 and bd_valid[1] = 0. Channel 0 state is unchanged throughout.
